ysyx_23060240_trap_ctrl: RTL

YSYX_23060240_TRAP_CTRL -- requirements
Module: ysyx_23060240_trap_ctrl

---
 rtl/ysyx_23060240_trap_ctrl_if.sv | 43 ++++
 rtl/ysyx_23060240_trap_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060240_trap_ctrl_if.sv
// rtl/ysyx_23060240_trap_ctrl_if.sv - request, instruction-side CSR, CSR-file and redirect signals of the trap controller
interface ysyx_23060240_trap_ctrl_if;
   logic        trap_req;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        mret_req;

   logic [11:0] ins_csr_addr;
   logic [31:0] ins_csr_wdata;
   logic        ins_csr_we;
   logic        ins_csr_re;
   logic [31:0] ins_csr_rdata;

   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_we;
   logic        csr_re;
   logic [31:0] csr_rdata;

   logic        trap_ack;
   logic        mret_ack;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;

   modport slave (
      input  trap_req, trap_pc, trap_cause, mret_req,
      input  ins_csr_addr, ins_csr_wdata, ins_csr_we, ins_csr_re,
      output ins_csr_rdata,
      output csr_addr, csr_wdata, csr_we, csr_re,
      input  csr_rdata,
      output trap_ack, mret_ack, redirect_valid, redirect_pc, stall
   );

   modport master (
      output trap_req, trap_pc, trap_cause, mret_req,
      output ins_csr_addr, ins_csr_wdata, ins_csr_we, ins_csr_re,
      input  ins_csr_rdata,
      input  csr_addr, csr_wdata, csr_we, csr_re,
      output csr_rdata,
      input  trap_ack, mret_ack, redirect_valid, redirect_pc, stall
   );
endinterface

// File: rtl/ysyx_23060240_trap_ctrl.sv
// rtl/ysyx_23060240_trap_ctrl.sv - trap entry / mret sequencer sharing one CSR-file port
// Owns the CSR port during a sequence; in IDLE it is a transparent pass-through for the instruction side.
module ysyx_23060240_trap_ctrl (
   input  logic                            clk,
   input  logic                            rst_n,
   ysyx_23060240_trap_ctrl_if.slave        bus
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] W_EPC   = 3'd1;
   localparam logic [2:0] W_CAUSE = 3'd2;
   localparam logic [2:0] R_STAT  = 3'd3;
   localparam logic [2:0] W_STAT  = 3'd4;
   localparam logic [2:0] R_VEC   = 3'd5;
   localparam logic [2:0] R_EPC   = 3'd6;
   localparam logic [2:0] REDIR   = 3'd7;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   logic [2:0]  state_q,  state_d;
   logic [31:0] pc_q,     pc_d;
   logic [31:0] cause_q,  cause_d;
   logic [31:0] stat_q,   stat_d;
   logic [31:0] target_q, target_d;
   logic        mret_q,   mret_d;

   logic        req_pending;
   logic        pass_thru;
   logic [31:0] stat_wr;

   assign req_pending = bus.trap_req | bus.mret_req;
   assign pass_thru   = rst_n && (state_q == IDLE) && !req_pending;

   // Kept apart from the port mux so the read path never forms a loop through csr_addr.
   assign bus.ins_csr_rdata = pass_thru ? bus.csr_rdata : 32'h0;

   always_comb begin
      stat_wr        = stat_q;
      stat_wr[12:11] = 2'b11;
      if (mret_q) begin
         stat_wr[3] = stat_q[7];
         stat_wr[7] = 1'b1;
      end else begin
         stat_wr[7] = stat_q[3];
         stat_wr[3] = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cause_d  = cause_q;
      stat_d   = stat_q;
      target_d = target_q;
      mret_d   = mret_q;
      case (state_q)
         IDLE: begin
            if (bus.trap_req) begin
               state_d = W_EPC;
               pc_d    = bus.trap_pc;
               cause_d = bus.trap_cause;
               mret_d  = 1'b0;
            end else if (bus.mret_req) begin
               state_d = R_STAT;
               mret_d  = 1'b1;
            end
         end
         W_EPC:   state_d = W_CAUSE;
         W_CAUSE: state_d = R_STAT;
         R_STAT: begin
            stat_d  = bus.csr_rdata;
            state_d = W_STAT;
         end
         W_STAT:  state_d = mret_q ? R_EPC : R_VEC;
         R_VEC, R_EPC: begin
            target_d = {bus.csr_rdata[31:2], 2'b00};
            state_d  = REDIR;
         end
         REDIR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= 32'h0;
         cause_q  <= 32'h0;
         stat_q   <= 32'h0;
         target_q <= 32'h0;
         mret_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cause_q  <= cause_d;
         stat_q   <= stat_d;
         target_q <= target_d;
         mret_q   <= mret_d;
      end
   end

   // Every output is gated by rst_n so nothing leaks out while reset is held.
   always_comb begin
      bus.csr_addr       = 12'h0;
      bus.csr_wdata      = 32'h0;
      bus.csr_we         = 1'b0;
      bus.csr_re         = 1'b0;
      bus.trap_ack       = 1'b0;
      bus.mret_ack       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.stall          = 1'b0;
      if (rst_n) begin
         bus.stall = (state_q != IDLE) | req_pending;
         case (state_q)
            IDLE: begin
               if (!req_pending) begin
                  bus.csr_addr  = bus.ins_csr_addr;
                  bus.csr_wdata = bus.ins_csr_wdata;
                  bus.csr_we    = bus.ins_csr_we;
                  bus.csr_re    = bus.ins_csr_re;
               end
            end
            W_EPC: begin
               bus.csr_addr  = CSR_MEPC;
               bus.csr_wdata = pc_q;
               bus.csr_we    = 1'b1;
            end
            W_CAUSE: begin
               bus.csr_addr  = CSR_MCAUSE;
               bus.csr_wdata = cause_q;
               bus.csr_we    = 1'b1;
            end
            R_STAT: begin
               bus.csr_addr = CSR_MSTATUS;
               bus.csr_re   = 1'b1;
            end
            W_STAT: begin
               bus.csr_addr  = CSR_MSTATUS;
               bus.csr_wdata = stat_wr;
               bus.csr_we    = 1'b1;
            end
            R_VEC: begin
               bus.csr_addr = CSR_MTVEC;
               bus.csr_re   = 1'b1;
            end
            R_EPC: begin
               bus.csr_addr = CSR_MEPC;
               bus.csr_re   = 1'b1;
            end
            REDIR: begin
               bus.redirect_valid = 1'b1;
               bus.redirect_pc    = target_q;
               bus.trap_ack       = !mret_q;
               bus.mret_ack       = mret_q;
            end
            default: ;
         endcase
      end
   end
endmodule
